// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART frame scheduler.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    ID,
    HI,
    LO,
    CHK
  } sched_state_t;

  localparam int NSRC = 3;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  localparam logic [1:0] CH_ADC_A = 2'd0;
  localparam logic [1:0] CH_ADC_B = 2'd1;
  localparam logic [1:0] CH_LMS   = 2'd2;

  // Next source index in round-robin order, wrapping after the last source.
  function automatic logic [1:0] next_src(input logic [1:0] src);
    return (src >= 2'(NSRC - 1)) ? 2'd0 : src + 2'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter. The pointer names the first source to
// consider; the pointer register itself lives in the parent.
module rr_arbiter3
  import uart_sched_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] next_ptr
);

  logic [1:0] idx;
  logic       found;

  // Walk the sources starting at ptr; the first requester wins and the
  // search for the following round starts just after it.
  always_comb begin
    gnt      = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = ptr;
    for (int i = 0; i < NSRC; i++) begin
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        next_ptr = next_src(idx);
        found    = 1'b1;
      end
      idx = next_src(idx);
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Decimates three sample streams, parks kept samples in per-source holding
// registers and serialises them as 5-byte checksummed frames to a UART.
module uart_frame_scheduler
  import uart_sched_pkg::*;
#(
  parameter int         DW     = 16,
  parameter int         DEC_W  = 8,
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [DEC_W-1:0]   decim,
  input  logic [NSRC-1:0]    src_valid,
  input  logic [NSRC*DW-1:0] src_data,
  output logic [7:0]         tx_byte,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [NSRC-1:0]    overrun,
  input  logic               ovr_clr,
  output logic               busy
);

  sched_state_t    state_reg;
  logic [7:0]      tx_byte_reg;
  logic            tx_valid_reg;
  logic [1:0]      ptr_reg;
  logic [1:0]      next_ptr;
  logic [5:0]      seq_reg;
  logic [7:0]      frame_id_reg;
  logic [DW-1:0]   frame_data_reg;
  logic [NSRC-1:0] ovr_reg;
  logic [NSRC-1:0] full_w;
  logic [NSRC-1:0] gnt;
  logic [NSRC-1:0] release_w;
  logic [NSRC-1:0] ovr_set;
  logic [DW-1:0]   hold_w [NSRC];
  logic            grant_en;
  logic            grant_fire;
  logic [1:0]      gnt_ch;
  logic [DW-1:0]   gnt_data;
  logic [7:0]      chk_byte;
  logic            accept;

  // Arbitration runs in IDLE, and in the single HDR cycle with tx_valid low
  // that separates back-to-back frames.
  assign grant_en   = (state_reg == IDLE) || (state_reg == HDR && !tx_valid_reg);
  assign grant_fire = grant_en && (|full_w);
  assign release_w  = grant_en ? gnt : '0;
  assign accept     = tx_valid_reg && tx_ready;
  assign chk_byte   = frame_id_reg + frame_data_reg[15:8] + frame_data_reg[7:0];

  rr_arbiter3 u_arb (
    .req      (full_w),
    .ptr      (ptr_reg),
    .gnt      (gnt),
    .next_ptr (next_ptr)
  );

  for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
    logic [DEC_W-1:0] cnt_reg;
    logic             full_reg;
    logic [DW-1:0]    hold_reg;
    logic             due;

    assign due         = src_valid[gi] && enable && (cnt_reg >= decim);
    assign ovr_set[gi] = due && full_reg && !release_w[gi];
    assign full_w[gi]  = full_reg;
    assign hold_w[gi]  = hold_reg;

    // Decimate the strobe stream and park due samples until granted;
    // a slot being released this cycle can accept a new sample at once.
    always_ff @(posedge clk_i or negedge rst_n) begin
      if (!rst_n) begin
        cnt_reg  <= '0;
        full_reg <= 1'b0;
        hold_reg <= '0;
      end else begin
        if (src_valid[gi] && enable)
          cnt_reg <= (cnt_reg >= decim) ? '0 : cnt_reg + 1'b1;
        if (due && (!full_reg || release_w[gi])) begin
          hold_reg <= src_data[gi*DW +: DW];
          full_reg <= 1'b1;
        end else if (release_w[gi]) begin
          full_reg <= 1'b0;
        end
      end
    end
  end

  // Turn the one-hot grant into a channel id and select its held sample.
  always_comb begin
    gnt_ch   = CH_ADC_A;
    gnt_data = hold_w[0];
    case (gnt)
      3'b010: begin
        gnt_ch   = CH_ADC_B;
        gnt_data = hold_w[1];
      end
      3'b100: begin
        gnt_ch   = CH_LMS;
        gnt_data = hold_w[2];
      end
      default: ;
    endcase
  end

  // Sticky drop flags; a new drop in the same cycle as a clear survives.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n)
      ovr_reg <= '0;
    else
      ovr_reg <= (ovr_clr ? '0 : ovr_reg) | ovr_set;
  end

  // Frame FSM: latch the granted sample, then step through the five bytes,
  // moving on only when the transmitter takes the current one.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      tx_byte_reg    <= '0;
      tx_valid_reg   <= 1'b0;
      ptr_reg        <= '0;
      seq_reg        <= '0;
      frame_id_reg   <= '0;
      frame_data_reg <= '0;
    end else if (grant_fire) begin
      frame_id_reg   <= {seq_reg, gnt_ch};
      frame_data_reg <= gnt_data;
      ptr_reg        <= next_ptr;
      seq_reg        <= seq_reg + 1'b1;
      state_reg      <= HDR;
      tx_byte_reg    <= HEADER;
      tx_valid_reg   <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: ;
        HDR: begin
          if (!tx_valid_reg) begin
            state_reg <= IDLE;
          end else if (accept) begin
            state_reg   <= ID;
            tx_byte_reg <= frame_id_reg;
          end
        end
        ID: begin
          if (accept) begin
            state_reg   <= HI;
            tx_byte_reg <= frame_data_reg[15:8];
          end
        end
        HI: begin
          if (accept) begin
            state_reg   <= LO;
            tx_byte_reg <= frame_data_reg[7:0];
          end
        end
        LO: begin
          if (accept) begin
            state_reg   <= CHK;
            tx_byte_reg <= chk_byte;
          end
        end
        CHK: begin
          if (accept) begin
            tx_valid_reg <= 1'b0;
            state_reg    <= (|full_w) ? HDR : IDLE;
          end
        end
        default: begin
          state_reg    <= IDLE;
          tx_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign tx_byte  = tx_byte_reg;
  assign tx_valid = tx_valid_reg;
  assign overrun  = ovr_reg;
  assign busy     = (state_reg != IDLE);

endmodule
